reloj_hex_display: RTL
======================

// Module: reloj_hex_display
// PURPOSE
//  Downstream consumer of the 8-bit CPU output PIO in the alarm-clock system.
//  Decodes byte commands written by software into six digit registers (HH:MM:SS)
//  and a control register, then drives six active-low 7-segment displays.
//  Provides hardware blinking of digit pairs for time/alarm set mode, so the CPU
//  writes only on value changes.
// PARAMETERS
//  BLINK_DIV  25000000  clk cycles per blink half-period (1 Hz blink at 50 MHz); min 2
// PORTS
//  clk           in   1  system clock; all logic on rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  pio_in        in   8  byte from output PIO: [7:5] index, [3:0] value, [4] ignored
//  hex0..hex5    out  7  segments {g,f,e,d,c,b,a}, active-low; hex0 = seconds units
//  blink_phase   out  1  current blink phase; 1 = blanked half
//  update_pulse  out  1  one-cycle pulse when a command is committed
// BEHAVIOUR
//  Reset (async assert, sync release) sets the following:
//   - in_q = 8'h00, matching the PIO reset value.
//   - All digit registers = 4'hF (blank).
//   - ctrl = 4'h0.
//   - Prescaler = 0, blink_phase = 0, update_pulse = 0.
//   - hex0..hex5 = 7'h7F (all segments off).
//  Command detect:
//   - in_q <= pio_in every cycle.
//   - A command is committed in the cycle where pio_in != in_q. The register
//     write and update_pulse = 1 both take effect at the next edge.
//   - A repeated identical byte is not a new command. This is harmless because
//     writes are idempotent.
//   - Byte 8'h00 directly after reset is not detected. Software writes 8'hF0
//     (index 7, NOP) before its first real command.
//  Index decode:
//   - 0..5: digit[idx] <= pio_in[3:0].
//   - 6: ctrl <= pio_in[3:0]. ctrl[0] blinks SS (hex1:hex0), ctrl[1] blinks MM
//     (hex3:hex2), ctrl[2] blinks HH (hex5:hex4), ctrl[3] blanks all digits.
//   - 7: NOP. update_pulse still fires; no register changes.
//  Value decode (pre-inversion, bit=1 lit):
//   - 0..9 give standard digits.
//   - A, b, C, d, E give hex letters.
//   - F gives blank.
//   - Values are not range-limited; software owns BCD legality.
//  Blink prescaler:
//   - Counts 0..BLINK_DIV-1 continuously; width = $clog2(BLINK_DIV).
//   - On the wrap (count == BLINK_DIV-1 -> 0), blink_phase toggles. It is
//     free-running and is not reset by ctrl writes.
//  Output stage:
//   - hexN registered: hexN <= ~seg(digit[N]) unless blanked, else 7'h7F.
//   - Blanked = ctrl[3] OR (blink_phase AND the pair's ctrl bit).
//  Latency:
//   - pio_in change at edge k-1 (first seen at edge k): digit register
//     updates at edge k+1, hex output updates at edge k+2.
//   - update_pulse high during cycle k+1 .. k+2.
//   - Changes in ctrl or blink_phase reach hex one edge later.
//  Simultaneous events:
//   - A command commit and a blink wrap in the same cycle are independent.
//     Both take effect.
//  Reset mid-operation:
//   - All state returns to reset values immediately; the displays go dark.
//   - A pending uncommitted command is lost. After release, the current
//     pio_in differs from in_q = 0, so one command is re-committed if pio_in
//     is nonzero.
// TESTING (bench uses BLINK_DIV=4)
//  1. Reset with pio_in=0: all hex = 7'h7F, update_pulse = 0. Hold 10 cycles:
//     no pulse, no change.
//  2. Write 8'h05, then 8'h23, then 8'hA9:
//     - hex0 = 7'h12 ('5') two edges after the change.
//     - hex1 = 7'h30 ('3').
//     - hex5 = 7'h10 ('9').
//     - Exactly three update_pulses.
//  3. Repeat 8'h23 for 20 cycles: exactly one update_pulse; hex1 stays 7'h30.
//  4. Write 8'hC2 (blink MM):
//     - blink_phase toggles every 4 cycles.
//     - hex3/hex2 alternate digit and 7'h7F.
//     - hex0/1/4/5 are steady.
//     - Then 8'hC8: all hex = 7'h7F regardless of phase.
//  5. Write 8'hE0 (NOP): one update_pulse, no register or hex change. Then
//     8'h0F: hex0 = 7'h7F (blank code).
//  6. Assert reset_n mid-blink with digits loaded:
//     - Outputs go 7'h7F asynchronously.
//     - After release with pio_in = 8'h47: digit2 = 7 re-committed, one
//       update_pulse.

Source files
------------

// File: rtl/reloj_hex_display.sv
// reloj_hex_display: decodes byte commands from the CPU output PIO into six
// digit registers (HH:MM:SS) plus a control register and drives six active-low
// 7-segment displays, with hardware blinking of digit pairs for set mode.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   pio_in        command byte: [7:5] index, [3:0] value, [4] ignored
//   hex0..hex5    segments {g,f,e,d,c,b,a}, active-low; hex0 = seconds units
//   blink_phase   current blink phase, 1 = blanked half
//   update_pulse  one-cycle pulse per committed command
module reloj_hex_display #(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pio_in,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       blink_phase,
  output logic       update_pulse
);

  localparam int unsigned CntW = $clog2(BLINK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  // Lit-high segment pattern {g,f,e,d,c,b,a}; F is the blank code.
  function automatic logic [6:0] seg_lit(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [7:0]      in_q;
  logic            cmd_q;      // in_q holds a byte that differed from its predecessor
  logic [3:0]      digit_q [6];
  logic [3:0]      ctrl_q;
  logic [CntW-1:0] presc_q;
  logic            blink_q;
  logic            pulse_q;
  logic [6:0]      hex_q   [6];
  logic [6:0]      hex_d   [6];

  always_comb begin
    for (int n = 0; n < 6; n++) begin
      hex_d[n] = 7'h7F;
      if (!(ctrl_q[3] || (blink_q && ctrl_q[n/2]))) begin
        hex_d[n] = ~seg_lit(digit_q[n]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q    <= 8'h00;
      cmd_q   <= 1'b0;
      ctrl_q  <= 4'h0;
      presc_q <= '0;
      blink_q <= 1'b0;
      pulse_q <= 1'b0;
      for (int n = 0; n < 6; n++) begin
        digit_q[n] <= 4'hF;
        hex_q[n]   <= 7'h7F;
      end
    end else begin
      in_q    <= pio_in;
      cmd_q   <= (pio_in != in_q);
      pulse_q <= cmd_q;

      // Commit the byte latched in in_q; index 7 is a NOP that still pulses.
      if (cmd_q) begin
        for (int n = 0; n < 6; n++) begin
          if (in_q[7:5] == 3'(n)) digit_q[n] <= in_q[3:0];
        end
        if (in_q[7:5] == 3'd6) ctrl_q <= in_q[3:0];
      end

      // Free-running blink prescaler, independent of command traffic.
      if (presc_q == CntMax) begin
        presc_q <= '0;
        blink_q <= ~blink_q;
      end else begin
        presc_q <= presc_q + 1'b1;
      end

      for (int n = 0; n < 6; n++) hex_q[n] <= hex_d[n];
    end
  end

  assign hex0         = hex_q[0];
  assign hex1         = hex_q[1];
  assign hex2         = hex_q[2];
  assign hex3         = hex_q[3];
  assign hex4         = hex_q[4];
  assign hex5         = hex_q[5];
  assign blink_phase  = blink_q;
  assign update_pulse = pulse_q;

endmodule
